input_conditioner: RTL and testbench

- Upstream stage for the board's switch/key inputs: synchronizes and debounces the 18 slide switches and 4 push-buttons before they reach the hex-display decode path in top.
- Outputs a glitch-free switch word to the hex decoders, plus a one-cycle change strobe and per-key press pulses for control logic.
- Runs entirely in the CLOCK_50 domain.

---
 rtl/input_conditioner.sv | 123 ++++++++++++
 tb/tb_input_conditioner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Synchronizes and debounces the board slide switches and push-buttons
//   ahead of the hex-display decode path. Everything runs on CLOCK_50.
//
//   Ports
//     CLOCK_50     in   1      system clock (50 MHz)
//     RESET_N      in   1      asynchronous active-low reset
//     SW_RAW       in   N_SW   raw slide-switch levels (asynchronous)
//     KEY_RAW      in   N_KEY  raw push-buttons, 0 = pressed (asynchronous)
//     SW_STABLE    out  N_SW   debounced switch word
//     SW_CHANGED   out  1      one-cycle strobe when any SW_STABLE bit changes
//     KEY_PRESSED  out  N_KEY  debounced key level, 1 = held
//     KEY_DOWN     out  N_KEY  one-cycle pulse per key on a debounced press
// ---------------------------------------------------------------------------
module input_conditioner #(
    parameter int N_SW            = 18,
    parameter int N_KEY           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [N_SW-1:0]  SW_RAW,
    input  logic [N_KEY-1:0] KEY_RAW,
    output logic [N_SW-1:0]  SW_STABLE,
    output logic             SW_CHANGED,
    output logic [N_KEY-1:0] KEY_PRESSED,
    output logic [N_KEY-1:0] KEY_DOWN
);

    // Switches occupy the low bits of the shared debounce vector, keys the top.
    localparam int N_BITS = N_SW + N_KEY;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N_SW-1:0]  sw_sync_p0;
    logic [SYNC_STAGES-1:0][N_KEY-1:0] key_sync_p0;

    logic [N_BITS-1:0] synced;
    logic [N_BITS-1:0] stable_p1;
    logic [N_BITS-1:0] stable_nxt;
    logic [CW-1:0]     cnt_p1  [N_BITS];
    logic [CW-1:0]     cnt_nxt [N_BITS];

    logic              sw_changed_p2;
    logic [N_KEY-1:0]  key_down_p2;

    // One debounce step for a single bit: returns {stable_next, count_next}.
    // The count reloads to zero at its last value instead of wrapping.
    function automatic logic [CW:0] debounce_step(input logic          s,
                                                  input logic          st,
                                                  input logic [CW-1:0] c);
        logic          st_n;
        logic [CW-1:0] c_n;
        st_n = st;
        if (s == st) begin
            c_n = '0;
        end else if (c == CNT_LAST) begin
            st_n = s;
            c_n  = '0;
        end else begin
            c_n = c + 1'b1;
        end
        return {st_n, c_n};
    endfunction

    // Keys are inverted after the chain so the internal level is 1 = pressed.
    assign synced = {~key_sync_p0[SYNC_STAGES-1], sw_sync_p0[SYNC_STAGES-1]};

    always_comb begin
        stable_nxt = stable_p1;
        for (int i = 0; i < N_BITS; i++) begin
            cnt_nxt[i] = '0;
            {stable_nxt[i], cnt_nxt[i]} = debounce_step(synced[i], stable_p1[i], cnt_p1[i]);
        end
    end

    // ---- stage p0: synchronizer chains ----
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_sync_p0  <= '0;
            key_sync_p0 <= '1;
        end else begin
            sw_sync_p0  <= {sw_sync_p0[SYNC_STAGES-2:0], SW_RAW};
            key_sync_p0 <= {key_sync_p0[SYNC_STAGES-2:0], KEY_RAW};
        end
    end

    // ---- stage p1: per-bit debounce counters and stable levels ----
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stable_p1 <= '0;
            for (int i = 0; i < N_BITS; i++) begin
                cnt_p1[i] <= '0;
            end
        end else begin
            stable_p1 <= stable_nxt;
            for (int i = 0; i < N_BITS; i++) begin
                cnt_p1[i] <= cnt_nxt[i];
            end
        end
    end

    // ---- stage p2: change strobe and press pulses ----
    // Computed from the same next-state as stable_p1 so each pulse lines up
    // with the first cycle the new level is visible on the outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_changed_p2 <= 1'b0;
            key_down_p2   <= '0;
        end else begin
            sw_changed_p2 <= |(stable_nxt[N_SW-1:0] ^ stable_p1[N_SW-1:0]);
            key_down_p2   <= stable_nxt[N_BITS-1:N_SW] & ~stable_p1[N_BITS-1:N_SW];
        end
    end

    assign SW_STABLE   = stable_p1[N_SW-1:0];
    assign KEY_PRESSED = stable_p1[N_BITS-1:N_SW];
    assign SW_CHANGED  = sw_changed_p2;
    assign KEY_DOWN    = key_down_p2;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//   Directed bench for input_conditioner with DEBOUNCE_CYCLES = 8 and
//   SYNC_STAGES = 2, so a held raw change lands on the 10th edge.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int N_SW  = 18;
    localparam int N_KEY = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_SW-1:0]  sw_raw;
    logic [N_KEY-1:0] key_raw;
    logic [N_SW-1:0]  sw_stable;
    logic             sw_changed;
    logic [N_KEY-1:0] key_pressed;
    logic [N_KEY-1:0] key_down;

    int n_tests = 0;
    int n_fail  = 0;
    int chg_cnt = 0;
    int kd0_cnt = 0;

    input_conditioner #(
        .N_SW(N_SW),
        .N_KEY(N_KEY),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N(rst_n),
        .SW_RAW(sw_raw),
        .KEY_RAW(key_raw),
        .SW_STABLE(sw_stable),
        .SW_CHANGED(sw_changed),
        .KEY_PRESSED(key_pressed),
        .KEY_DOWN(key_down)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (sw_changed)  chg_cnt++;
        if (key_down[0]) kd0_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Active-low 7-segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000; 4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100; 4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001; 4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010; 4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000; 4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000; 4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110; 4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110; default: hex7 = 7'b0001110;
        endcase
    endfunction

    initial begin
        int base;
        int kbase;
        logic moved;

        // 1. Reset with all switches on
        rst_n   = 1'b0;
        sw_raw  = 18'h3FFFF;
        key_raw = 4'hF;
        base    = chg_cnt;
        step(5);
        chk("rst_sw_stable", 32'(sw_stable), 32'h0);
        chk("rst_key_pressed", 32'(key_pressed), 32'h0);
        chk("rst_sw_changed", 32'(sw_changed), 32'h0);
        chk("rst_key_down", 32'(key_down), 32'h0);
        chk("rst_no_pulses", 32'(chg_cnt - base), 32'h0);
        rst_n = 1'b1;
        step(9);
        chk("rst_rel_edge9", 32'(sw_stable), 32'h0);
        step(1);
        chk("rst_rel_edge10", 32'(sw_stable), 32'h3FFFF);
        chk("rst_rel_changed", 32'(sw_changed), 32'h1);
        step(3);
        chk("rst_rel_one_pulse", 32'(chg_cnt - base), 32'h1);

        // 2. Clean change 0 -> 0000F
        sw_raw = 18'h0;
        step(15);
        chk("clr_settle", 32'(sw_stable), 32'h0);
        sw_raw = 18'h0000F;
        step(9);
        chk("clean_edge9", 32'(sw_stable), 32'h0);
        step(1);
        chk("clean_edge10", 32'(sw_stable), 32'h0000F);
        chk("clean_changed", 32'(sw_changed), 32'h1);
        chk("clean_hex0", 32'(hex7(sw_stable[3:0])), 32'h0E);
        step(1);
        chk("clean_changed_drop", 32'(sw_changed), 32'h0);

        // 3. Bounce on SW[4]: 1,0,1,0 every 3 cycles, then hold 1
        base  = chg_cnt;
        moved = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sw_raw[4] = ~k[0];
            for (int c = 0; c < 3; c++) begin
                step(1);
                if (sw_stable[4] !== 1'b0) moved = 1'b1;
            end
        end
        sw_raw[4] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step(1);
            if (sw_stable[4] !== 1'b0) moved = 1'b1;
        end
        chk("bounce_held_low", 32'(moved), 32'h0);
        step(1);
        chk("bounce_edge10", 32'(sw_stable), 32'h0001F);
        step(3);
        chk("bounce_one_pulse", 32'(chg_cnt - base), 32'h1);

        // 4. Key glitch, press, release
        kbase = kd0_cnt;
        key_raw[0] = 1'b0;
        step(5);
        key_raw[0] = 1'b1;
        step(15);
        chk("glitch_no_press", 32'(key_pressed), 32'h0);
        chk("glitch_no_pulse", 32'(kd0_cnt - kbase), 32'h0);
        key_raw[0] = 1'b0;
        step(9);
        chk("press_edge9", 32'(key_pressed), 32'h0);
        step(1);
        chk("press_edge10", 32'(key_pressed), 32'h1);
        chk("press_key_down", 32'(key_down), 32'h1);
        step(10);
        chk("press_held", 32'(key_pressed), 32'h1);
        chk("press_one_pulse", 32'(kd0_cnt - kbase), 32'h1);
        key_raw[0] = 1'b1;
        step(15);
        chk("release_level", 32'(key_pressed), 32'h0);
        chk("release_no_pulse", 32'(kd0_cnt - kbase), 32'h1);

        // 5. Simultaneous SW[0] and SW[17]
        sw_raw = 18'h0;
        step(15);
        base   = chg_cnt;
        sw_raw = 18'h20001;
        step(9);
        chk("simul_edge9", 32'(sw_stable), 32'h0);
        step(1);
        chk("simul_edge10", 32'(sw_stable), 32'h20001);
        step(3);
        chk("simul_one_pulse", 32'(chg_cnt - base), 32'h1);

        // 6. Reset pulsed mid-debounce on SW[8]
        sw_raw = 18'h0;
        step(15);
        sw_raw = 18'h00100;
        step(6);
        chk("midrst_pre", 32'(sw_stable), 32'h0);
        rst_n = 1'b0;
        step(2);
        chk("midrst_during", 32'(sw_stable), 32'h0);
        base  = chg_cnt;
        rst_n = 1'b1;
        step(9);
        chk("midrst_edge9", 32'(sw_stable), 32'h0);
        step(1);
        chk("midrst_edge10", 32'(sw_stable), 32'h00100);
        chk("midrst_changed", 32'(sw_changed), 32'h1);
        step(3);
        chk("midrst_one_pulse", 32'(chg_cnt - base), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
